// File: rtl/serial_add_pkg.sv
// serial_add_pkg: state encoding, default width and majority helper shared by the serial adder files
package serial_add_pkg;
    localparam int DEF_WIDTH = 8;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;
    function automatic logic maj(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction
endpackage

// File: rtl/serial_add_cell.sv
// serial_add_cell: 1-bit full adder whose carry lives in a register between bit steps
module serial_add_cell
    import serial_add_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic set,
    input  logic en,
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);
    logic carry_q, carry_d;
    // carry init at accept wins over advancing; otherwise hold
    always_comb carry_d = clr ? 1'b0 : set ? 1'b1 : en ? maj(a, b, carry_q) : carry_q;
    // carry register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) carry_q <= 1'b0;
        else carry_q <= carry_d;
    end
    assign sum   = a ^ b ^ carry_q;
    assign carry = carry_q;
endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: handshake sequencer feeding operands LSB-first through serial_add_cell; define SUBTRACT_EN for sub_in
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
`ifdef SUBTRACT_EN
    input  logic             sub_in,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout
);
    localparam int CNT_W = $clog2(WIDTH);
    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] sa_q, sb_q, res_q, b_ld_d;
    logic             in_ready_q, out_valid_q, sub_d, accept, shift_en, last, sum_bit, carry;
`ifdef SUBTRACT_EN
    assign sub_d = sub_in;
`else
    assign sub_d = 1'b0;
`endif
    assign accept   = in_valid && in_ready_q;
    assign shift_en = state_q == ST_SHIFT;
    assign last     = cnt_q == CNT_W'(WIDTH - 1);
    // subtraction loads B inverted; the cell's preset carry supplies the +1
    always_comb b_ld_d = sub_d ? ~b_in : b_in;
    serial_add_cell u_cell (
        .clk    (clk),
        .reset_n(reset_n),
        .clr    (accept && !sub_d),
        .set    (accept && sub_d),
        .en     (shift_en),
        .a      (sa_q[0]),
        .b      (sb_q[0]),
        .sum    (sum_bit),
        .carry  (carry)
    );
    // FSM with bit counter, operand/result shifters and registered handshake flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            sa_q        <= '0;
            sb_q        <= '0;
            res_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        sa_q       <= a_in;
                        sb_q       <= b_ld_d;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    sa_q  <= sa_q >> 1;
                    sb_q  <= sb_q >> 1;
                    res_q <= {sum_bit, res_q[WIDTH-1:1]};
                    cnt_q <= last ? cnt_q : cnt_q + 1'b1;
                    if (last) begin
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    cnt_q       <= '0;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end
    // in_ready is forced low while reset is held and rises the moment reset releases
    assign in_ready  = in_ready_q && reset_n;
    assign out_valid = out_valid_q;
    assign sum_out   = res_q;
    assign cout      = carry;
endmodule

// File: tb/tb_serial_add_ctrl.sv
`timescale 1ns/1ps
// tb_serial_add_ctrl: vector table, directed corner sequences and random scoreboard for serial_add_ctrl
module tb_serial_add_ctrl;
    localparam int W = 8;
`ifdef SUBTRACT_EN
    localparam bit HAS_SUB = 1'b1;
`else
    localparam bit HAS_SUB = 1'b0;
`endif
    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W-1:0] sum;
        logic         co;
    } vec_t;
    logic         clk = 1'b0, reset_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0, sub_v = 1'b0;
    logic         in_ready, out_valid, cout;
    logic [W-1:0] a_in = '0, b_in = '0, sum_out;
    int           checks = 0, errors = 0;
    logic [W:0]   exp_q[$];
    longint       acc_t[$];
    logic [W:0]   e;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_in     (a_in),
        .b_in     (b_in),
`ifdef SUBTRACT_EN
        .sub_in   (sub_v),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum_out  (sum_out),
        .cout     (cout)
    );

    always #5 clk = ~clk;

    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        if (s) return {a >= b, W'(a - b)};
        return (W+1)'(a) + (W+1)'(b);
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        bit rdy;
        a_in = a;
        b_in = b;
        in_valid = 1'b1;
        do begin
            rdy = in_ready;
            @(posedge clk); #1;
            n++;
        end while (!rdy && n < 100);
        check("accept", rdy, 1);
        in_valid = 1'b0;
        a_in = W'($urandom);
        b_in = W'($urandom);
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    // scoreboard: model results pushed on accept, compared on result handshake
    always @(negedge clk) begin
        if (reset_n) begin
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a_in, b_in, sub_v));
                acc_t.push_back($time);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got result %0h with no pending op", {cout, sum_out});
                end else begin
                    e = exp_q.pop_front();
                    check("sb_result", {cout, sum_out}, e);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[$];
        int   lat, base, cyc, held;
        tbl.push_back('{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0});
        tbl.push_back('{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1});
        tbl.push_back('{8'h00, 8'h00, 1'b0, 8'h00, 1'b0});
        tbl.push_back('{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0});
        tbl.push_back('{8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1});
        tbl.push_back('{8'h80, 8'h80, 1'b0, 8'h00, 1'b1});
`ifdef SUBTRACT_EN
        tbl.push_back('{8'h10, 8'h01, 1'b1, 8'h0F, 1'b1});
        tbl.push_back('{8'h01, 8'h02, 1'b1, 8'hFF, 1'b0});
        tbl.push_back('{8'h37, 8'h37, 1'b1, 8'h00, 1'b1});
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum_out, 0);
        check("rst_cout", cout, 0);
        reset_n = 1'b1;
        #1;
        check("rel_in_ready", in_ready, 1);
        @(posedge clk); #1;

        foreach (tbl[i]) begin
            sub_v = tbl[i].sub;
            send(tbl[i].a, tbl[i].b);
            wait_done(lat);
            check("latency", lat, W);
            check("vec_sum", sum_out, tbl[i].sum);
            check("vec_cout", cout, tbl[i].co);
            check("vec_in_ready_done", in_ready, 0);
            release_result();
            check("vec_back_idle", in_ready, 1);
            check("vec_out_valid_low", out_valid, 0);
        end
        sub_v = 1'b0;

        send(8'hC3, 8'h4E);
        wait_done(lat);
        held = acc_t.size();
        a_in = 8'h11;
        b_in = 8'h22;
        in_valid = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            check("bp_out_valid", out_valid, 1);
            check("bp_sum", sum_out, 8'h11);
            check("bp_cout", cout, 1);
            check("bp_in_ready", in_ready, 0);
        end
        check("bp_no_accept", acc_t.size(), held);
        release_result();
        check("bp_idle_ready", in_ready, 1);
        send(8'h11, 8'h22);
        check("bp_accept_after", acc_t.size(), held + 1);
        wait_done(lat);
        check("bp_next_sum", sum_out, 8'h33);
        check("bp_next_cout", cout, 0);
        release_result();

        send(8'hAA, 8'h55);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        exp_q.delete();
        check("abort_out_valid", out_valid, 0);
        check("abort_in_ready", in_ready, 0);
        check("abort_sum", sum_out, 0);
        check("abort_cout", cout, 0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
        check("abort_rel_ready", in_ready, 1);
        @(posedge clk); #1;
        send(8'h01, 8'h02);
        wait_done(lat);
        check("abort_latency", lat, W);
        check("abort_next_sum", sum_out, 8'h03);
        check("abort_next_cout", cout, 0);
        release_result();

        base = acc_t.size();
        cyc = 0;
        out_ready = 1'b1;
        in_valid = 1'b1;
        while (acc_t.size() < base + 1000 && cyc < 20000) begin
            a_in = W'($urandom);
            b_in = W'($urandom);
            sub_v = HAS_SUB & 1'($urandom);
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        check("b2b_count", acc_t.size() - base, 1000);
        for (int i = base + 1; i < acc_t.size(); i++)
            check("b2b_spacing", acc_t[i] - acc_t[i-1], (W + 2) * 10);
        repeat (W + 4) @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("sb_drained", exp_q.size(), 0);
        check("final_idle", in_ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
